// File: rtl/axil_arbiter_2to1.sv
// Round-robin 2:1 AXI4-Lite arbiter; one downstream transaction in flight at a time.
// Payloads pass straight through, only valid/ready are steered by the FSM.
module axil_arbiter_2to1 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0
  input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
  input  logic [2:0]            s0_axil_awprot,
  input  logic                  s0_axil_awvalid,
  output logic                  s0_axil_awready,
  input  logic [DATA_WIDTH-1:0] s0_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s0_axil_wstrb,
  input  logic                  s0_axil_wvalid,
  output logic                  s0_axil_wready,
  output logic [1:0]            s0_axil_bresp,
  output logic                  s0_axil_bvalid,
  input  logic                  s0_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
  input  logic [2:0]            s0_axil_arprot,
  input  logic                  s0_axil_arvalid,
  output logic                  s0_axil_arready,
  output logic [DATA_WIDTH-1:0] s0_axil_rdata,
  output logic [1:0]            s0_axil_rresp,
  output logic                  s0_axil_rvalid,
  input  logic                  s0_axil_rready,
  // master 1
  input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
  input  logic [2:0]            s1_axil_awprot,
  input  logic                  s1_axil_awvalid,
  output logic                  s1_axil_awready,
  input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
  input  logic                  s1_axil_wvalid,
  output logic                  s1_axil_wready,
  output logic [1:0]            s1_axil_bresp,
  output logic                  s1_axil_bvalid,
  input  logic                  s1_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
  input  logic [2:0]            s1_axil_arprot,
  input  logic                  s1_axil_arvalid,
  output logic                  s1_axil_arready,
  output logic [DATA_WIDTH-1:0] s1_axil_rdata,
  output logic [1:0]            s1_axil_rresp,
  output logic                  s1_axil_rvalid,
  input  logic                  s1_axil_rready,
  // downstream slave
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_RESP} state_t;

  state_t state;
  logic   grant, last, is_write, aw_done, w_done;

  logic req0, req1, sel, sel_wr;
  logic g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic up_awready, up_wready, up_bvalid, up_arready, up_rvalid;

  assign req0   = s0_axil_awvalid | s0_axil_arvalid;
  assign req1   = s1_axil_awvalid | s1_axil_arvalid;
  // both requesting: the master not served last wins
  assign sel    = (req0 & req1) ? ~last : req1;
  assign sel_wr = sel ? s1_axil_awvalid : s0_axil_awvalid;

  assign g_awvalid = grant ? s1_axil_awvalid : s0_axil_awvalid;
  assign g_wvalid  = grant ? s1_axil_wvalid  : s0_axil_wvalid;
  assign g_bready  = grant ? s1_axil_bready  : s0_axil_bready;
  assign g_arvalid = grant ? s1_axil_arvalid : s0_axil_arvalid;
  assign g_rready  = grant ? s1_axil_rready  : s0_axil_rready;

  assign m_axil_awvalid = (state == WR) & g_awvalid & ~aw_done;
  assign m_axil_wvalid  = (state == WR) & g_wvalid  & ~w_done;
  assign m_axil_bready  = (state == WR_RESP) & is_write & g_bready;
  assign m_axil_arvalid = (state == RD) & g_arvalid;
  assign m_axil_rready  = (state == RD_RESP) & ~is_write & g_rready;

  assign up_awready = (state == WR) & m_axil_awready & ~aw_done;
  assign up_wready  = (state == WR) & m_axil_wready  & ~w_done;
  assign up_bvalid  = (state == WR_RESP) & is_write & m_axil_bvalid;
  assign up_arready = (state == RD) & m_axil_arready;
  assign up_rvalid  = (state == RD_RESP) & ~is_write & m_axil_rvalid;

  assign aw_hs = m_axil_awvalid & m_axil_awready;
  assign w_hs  = m_axil_wvalid  & m_axil_wready;
  assign b_hs  = m_axil_bvalid  & m_axil_bready;
  assign ar_hs = m_axil_arvalid & m_axil_arready;
  assign r_hs  = m_axil_rvalid  & m_axil_rready;

  assign s0_axil_awready = up_awready & ~grant;
  assign s0_axil_wready  = up_wready  & ~grant;
  assign s0_axil_bvalid  = up_bvalid  & ~grant;
  assign s0_axil_arready = up_arready & ~grant;
  assign s0_axil_rvalid  = up_rvalid  & ~grant;
  assign s1_axil_awready = up_awready & grant;
  assign s1_axil_wready  = up_wready  & grant;
  assign s1_axil_bvalid  = up_bvalid  & grant;
  assign s1_axil_arready = up_arready & grant;
  assign s1_axil_rvalid  = up_rvalid  & grant;

  assign m_axil_awaddr = grant ? s1_axil_awaddr : s0_axil_awaddr;
  assign m_axil_awprot = grant ? s1_axil_awprot : s0_axil_awprot;
  assign m_axil_wdata  = grant ? s1_axil_wdata  : s0_axil_wdata;
  assign m_axil_wstrb  = grant ? s1_axil_wstrb  : s0_axil_wstrb;
  assign m_axil_araddr = grant ? s1_axil_araddr : s0_axil_araddr;
  assign m_axil_arprot = grant ? s1_axil_arprot : s0_axil_arprot;

  // responses are broadcast; only the valid is steered
  assign s0_axil_bresp = m_axil_bresp;
  assign s1_axil_bresp = m_axil_bresp;
  assign s0_axil_rdata = m_axil_rdata;
  assign s1_axil_rdata = m_axil_rdata;
  assign s0_axil_rresp = m_axil_rresp;
  assign s1_axil_rresp = m_axil_rresp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= 1'b0;
      last     <= 1'b1;
      is_write <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req0 | req1) begin
          grant <= sel;
          if (sel_wr) begin
            state    <= WR;
            is_write <= 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
          end else begin
            state    <= RD;
            is_write <= 1'b0;
          end
        end
        WR: begin
          // AW and W may complete in either order or together
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done | aw_hs) & (w_done | w_hs)) state <= WR_RESP;
        end
        WR_RESP: if (b_hs) begin
          last  <= grant;
          state <= IDLE;
        end
        RD: if (ar_hs) state <= RD_RESP;
        RD_RESP: if (r_hs) begin
          last  <= grant;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/axil_arbiter_2to1.md
# axil_arbiter_2to1

Two-master to one-slave AXI4-Lite arbiter that shares the AXI4-Lite register slave between two upstream requesters, for example a host bridge and an on-chip sequencer. Arbitration is round-robin with exactly one transaction outstanding on the downstream port at any time. All channel payloads pass straight through the arbiter. The `m_axil_*` port connects directly to the slave's `s_axil_*` port.

## Interface
- DATA_WIDTH, 32, data bus width in bits
- ADDR_WIDTH, 32, address bus width in bits
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width
- clk  in  1  single clock; all logic is rising-edge
- rst  in  1  asynchronous, active-high reset
- s0_axil_awaddr/awprot/awvalid in, awready out  ADDR_WIDTH/3/1/1  master 0 write-address channel
- s0_axil_wdata/wstrb/wvalid in, wready out  DATA_WIDTH/STRB_WIDTH/1/1  master 0 write-data channel
- s0_axil_bresp/bvalid out, bready in  2/1/1  master 0 write-response channel
- s0_axil_araddr/arprot/arvalid in, arready out  ADDR_WIDTH/3/1/1  master 0 read-address channel
- s0_axil_rdata/rresp/rvalid out, rready in  DATA_WIDTH/2/1/1  master 0 read-data channel
- s1_axil_*  same five channel bundles as s0, for master 1
- m_axil_awaddr/awprot/awvalid out, awready in  ADDR_WIDTH/3/1/1  downstream write-address channel
- m_axil_wdata/wstrb/wvalid out, wready in  DATA_WIDTH/STRB_WIDTH/1/1  downstream write-data channel
- m_axil_bresp/bvalid in, bready out  2/1/1  downstream write-response channel
- m_axil_araddr/arprot/arvalid out, arready in  ADDR_WIDTH/3/1/1  downstream read-address channel
- m_axil_rdata/rresp/rvalid in, rready out  DATA_WIDTH/2/1/1  downstream read-data channel

## Operation
- FSM states: IDLE, WR, WR_RESP, RD, RD_RESP. Registers: grant (1 bit), last (1 bit), is_write, aw_done, w_done.
- Request detection in IDLE:
  - write request of master i = si_awvalid.
  - read request of master i = si_arvalid.
  - A master requests if it has either.
- Master selection: if only one master requests, grant it. If both request, grant !last.
- Channel selection: if the granted master has both a write and a read pending, the write wins.
- On a grant, go to WR (clear aw_done and w_done) or to RD.
- WR state:
  - m_axil_awvalid = s[g]_awvalid & !aw_done, and s[g]_awready = m_axil_awready & !aw_done.
  - W channel follows the same rule using w_done.
  - Set aw_done / w_done on each handshake; AW and W may complete in either order or in the same cycle.
  - Once both are done, go to WR_RESP.
- WR_RESP: s[g]_bvalid = m_axil_bvalid, m_axil_bready = s[g]_bready. On the B handshake, set last <= g and go to IDLE.
- RD: forward AR the same way. On the AR handshake, go to RD_RESP.
- RD_RESP: forward R. On the R handshake, set last <= g and go to IDLE.
- Gating and payload:
  - All valid and ready signals toward the non-granted master are 0.
  - All valid and ready signals on both sides are 0 in IDLE and on channels not active in the current state.
  - Payload outputs (addr, prot, wdata, wstrb) are muxed from master g combinationally.
  - rdata, rresp and bresp are broadcast to both masters; only the valid signal is gated.
- The arbiter performs no address decoding, generates no responses and does not modify any resp code.

## Timing
- Reset values:
  - state = IDLE, last = 1 (so master 0 wins the first contention), grant = 0, flags = 0.
  - Every valid and ready output is 0 while rst is high and in the first cycle after release.
- Grant latency: a request sampled in IDLE in cycle N is granted at edge N. Forwarded valids appear in cycle N+1.
- After each response handshake there is one mandatory IDLE cycle, so the minimum downstream transaction spacing is 1 IDLE + 2 cycles.
- Per-channel pass-through is combinational, with 0 added cycles once in state.
- Reset mid-transaction aborts immediately: the FSM returns to IDLE and all valids drop in the same cycle. The downstream slave shares rst.
- An upstream master may deassert valid only after a handshake (AXI rule). The arbiter does not check for violations.

## Test plan
- Single write: s0 sends awaddr 0x10, wdata 0xDEADBEEF, wstrb 0xF -> identical values appear on m_axil_*; s0_bvalid arrives with bresp 0; no s1 valid or ready ever rises.
- Contention after reset: s0 and s1 both assert awvalid in the same cycle -> s0 is served fully, then exactly 1 IDLE cycle, then s1; downstream order is s0 then s1.
- Sustained contention: both masters continuously issue reads to 0x0/0x4 -> grants alternate 0,1,0,1 over 8 transactions; each master receives its own rdata.
- Mixed request: s1 asserts awvalid and arvalid together -> the write is completed first, the read in the next grant.
- Backpressure and ordering: W arrives 2 cycles before AW, and m_axil_awready is held low for 3 cycles -> s0_wready pulses on the W handshake, s0_awready pulses exactly when m_axil_awready does, and WR_RESP is entered only after both.
- Reset in RD_RESP: rst is pulsed while m_axil_rvalid=1 -> all valid and ready outputs are 0 within the same cycle; after release, simultaneous requests from both masters are granted to s0.
